// File: rtl/alu_div_if.sv
// alu_div_if - start/busy/done bus between a requester and alu_div.
// ALU_DIV_SIGNED_EN adds the sign_en request bit.
interface alu_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend_h;
    logic [WIDTH-1:0] dividend_l;
    logic [WIDTH-1:0] divisor;
`ifdef ALU_DIV_SIGNED_EN
    logic             sign_en;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, dividend_h, dividend_l, divisor,
`ifdef ALU_DIV_SIGNED_EN
        output sign_en,
`endif
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, dividend_h, dividend_l, divisor,
`ifdef ALU_DIV_SIGNED_EN
        input  sign_en,
`endif
        output busy, done, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/alu_div.sv
// alu_div - multi-cycle restoring divider, {dividend_h,dividend_l} / divisor.
// Define ALU_DIV_SIGNED_EN for two's-complement mode selected by sign_en.
module alu_div #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    alu_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] in_h, in_l, in_dvs;
    logic             in_sgn, in_negq, in_negr;

    logic [WIDTH:0]   rem_ext;
    logic [WIDTH-1:0] step_r, step_q;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] out_quot, out_rem;
    logic             out_ovf;

`ifdef ALU_DIV_SIGNED_EN
    logic [2*WIDTH-1:0] dvd_raw, dvd_mag;

    // Operand magnitudes and result signs, taken at the accepting edge
    always_comb begin
        dvd_raw = {bus.dividend_h, bus.dividend_l};
        dvd_mag = dvd_raw;
        in_dvs  = bus.divisor;
        in_sgn  = bus.sign_en;
        in_negq = 1'b0;
        in_negr = 1'b0;
        if (bus.sign_en) begin
            if (bus.dividend_h[WIDTH-1]) begin
                dvd_mag = -dvd_raw;
            end
            if (bus.divisor[WIDTH-1]) begin
                in_dvs = -bus.divisor;
            end
            in_negr = bus.dividend_h[WIDTH-1];
            in_negq = bus.dividend_h[WIDTH-1] ^ bus.divisor[WIDTH-1];
        end
        in_h = dvd_mag[2*WIDTH-1:WIDTH];
        in_l = dvd_mag[WIDTH-1:0];
    end
`else
    // Unsigned only: operands pass straight through
    always_comb begin
        in_h    = bus.dividend_h;
        in_l    = bus.dividend_l;
        in_dvs  = bus.divisor;
        in_sgn  = 1'b0;
        in_negq = 1'b0;
        in_negr = 1'b0;
    end
`endif

    // One restoring step; compare on WIDTH+1 bits so the shifted-out bit counts
    always_comb begin
        rem_ext = {r_q, q_q[WIDTH-1]};
        step_q  = {q_q[WIDTH-2:0], 1'b0};
        step_r  = rem_ext[WIDTH-1:0];
        if (rem_ext >= {1'b0, dvs_q}) begin
            step_r    = rem_ext[WIDTH-1:0] - dvs_q;
            step_q[0] = 1'b1;
        end
    end

    // Sign fix-up and signed range check on the final step
    always_comb begin
        lim      = {1'b0, {(WIDTH-1){1'b1}}} + {{(WIDTH-1){1'b0}}, negq_q};
        out_ovf  = sgn_q && (step_q > lim);
        out_quot = negq_q ? -step_q : step_q;
        out_rem  = negr_q ? -step_r : step_r;
        if (out_ovf) begin
            out_quot = '1;
            out_rem  = '0;
        end
    end

    // Next-state: accept in IDLE/DONE, fast path or WIDTH steps in CALC
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = bus.dividend_l;
                        dz_d    = 1'b1;
                    end else if (in_h >= in_dvs) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        r_d     = in_h;
                        q_d     = in_l;
                        dvs_d   = in_dvs;
                        cnt_d   = '0;
                        sgn_d   = in_sgn;
                        negq_d  = in_negq;
                        negr_d  = in_negr;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = out_quot;
                    rem_d   = out_rem;
                    ovf_d   = out_ovf;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div - directed vector table plus reset / back-to-back sequences.
// Signed vectors run only when ALU_DIV_SIGNED_EN is defined.
module tb_alu_div;
    logic clk;
    logic rst;

    alu_div_if #(.WIDTH(32)) bus ();

    alu_div #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] d;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive operands and hold start across one rising edge
    task automatic launch(input logic [31:0] h, input logic [31:0] l,
                          input logic [31:0] d, input logic sgn);
        bus.dividend_h = h;
        bus.dividend_l = l;
        bus.divisor    = d;
`ifdef ALU_DIV_SIGNED_EN
        bus.sign_en    = sgn;
`else
        if (sgn) $display("note: sign_en ignored in unsigned build");
`endif
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
    endtask

    // Count cycles after the accepting edge until done (bounded)
    task automatic wait_done(input int c0, output int cyc, output int bcnt);
        cyc  = c0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cyc, bcnt;
        launch(v.h, v.l, v.d, v.sgn);
        wait_done(1, cyc, bcnt);
        chk($sformatf("v%0d.lat", i), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d.busy_cycles", i), 64'(bcnt), 64'(v.lat == 1 ? 0 : 32));
        chk($sformatf("v%0d.q", i), 64'(bus.quotient), 64'(v.q));
        chk($sformatf("v%0d.r", i), 64'(bus.remainder), 64'(v.r));
        chk($sformatf("v%0d.dz", i), 64'(bus.div_zero), 64'(v.dz));
        chk($sformatf("v%0d.ovf", i), 64'(bus.overflow), 64'(v.ovf));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.done_pulse", i), 64'(bus.done), 64'(0));
        chk($sformatf("v%0d.q_held", i), 64'(bus.quotient), 64'(v.q));
    endtask

    vec_t tbl[15];

    initial begin
        int cyc, bcnt, ndone;

        tbl[0]  = '{32'h0, 32'd12, 32'd6, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 33};
        tbl[1]  = '{32'h3fff_ffff, 32'h1, 32'h7fff_ffff, 1'b0,
                    32'h7fff_ffff, 32'd0, 1'b0, 1'b0, 33};
        tbl[2]  = '{32'h0, 32'd77, 32'd0, 1'b0, 32'hffff_ffff, 32'd77, 1'b1, 1'b0, 1};
        tbl[3]  = '{32'd5, 32'd0, 32'd5, 1'b0, 32'hffff_ffff, 32'd0, 1'b0, 1'b1, 1};
        tbl[4]  = '{32'h0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33};
        tbl[5]  = '{32'h1, 32'h0, 32'd2, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 33};
        tbl[6]  = '{32'h0, 32'hffff_ffff, 32'd1, 1'b0, 32'hffff_ffff, 32'd0, 1'b0, 1'b0, 33};
        tbl[7]  = '{32'hffff_fffe, 32'hffff_ffff, 32'hffff_ffff, 1'b0,
                    32'hffff_ffff, 32'hffff_fffe, 1'b0, 1'b0, 33};
        tbl[8]  = '{32'h0, 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 1'b0, 33};
        tbl[9]  = '{32'hffff_fffe, 32'h0, 32'hffff_fffe, 1'b0,
                    32'hffff_ffff, 32'd0, 1'b0, 1'b1, 1};
        tbl[10] = '{32'hffff_ffff, 32'hffff_ffec, 32'd6, 1'b0,
                    32'hffff_ffff, 32'd0, 1'b0, 1'b1, 1};
        tbl[11] = '{32'hffff_ffff, 32'hffff_ffec, 32'd6, 1'b1,
                    32'hffff_fffd, 32'hffff_fffe, 1'b0, 1'b0, 33};
        tbl[12] = '{32'h0, 32'd20, 32'hffff_fffa, 1'b1,
                    32'hffff_fffd, 32'd2, 1'b0, 1'b0, 33};
        tbl[13] = '{32'h0, 32'h8000_0000, 32'd1, 1'b1,
                    32'hffff_ffff, 32'd0, 1'b0, 1'b1, 33};
        tbl[14] = '{32'hffff_ffff, 32'h8000_0000, 32'd1, 1'b1,
                    32'h8000_0000, 32'd0, 1'b0, 1'b0, 33};

        bus.start      = 1'b0;
        bus.dividend_h = '0;
        bus.dividend_l = '0;
        bus.divisor    = '0;
`ifdef ALU_DIV_SIGNED_EN
        bus.sign_en    = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(bus.busy), 64'(0));
        chk("rst.done", 64'(bus.done), 64'(0));
        chk("rst.q", 64'(bus.quotient), 64'(0));
        chk("rst.r", 64'(bus.remainder), 64'(0));
        chk("rst.flags", 64'({bus.div_zero, bus.overflow}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
`ifndef ALU_DIV_SIGNED_EN
            if (tbl[i].sgn) continue;
`endif
            run_vec(i, tbl[i]);
        end

        // Reset ten cycles into CALC aborts the operation
        launch(32'h0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("abort.busy_before", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        #2;
        chk("abort.busy", 64'(bus.busy), 64'(0));
        chk("abort.done", 64'(bus.done), 64'(0));
        chk("abort.q", 64'(bus.quotient), 64'(0));
        chk("abort.r", 64'(bus.remainder), 64'(0));
        chk("abort.flags", 64'({bus.div_zero, bus.overflow}), 64'(0));
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'(0));
        run_vec(100, tbl[4]);

        // Back-to-back start in the done cycle; start during CALC is ignored
        launch(32'h0, 32'd12, 32'd6, 1'b0);
        wait_done(1, cyc, bcnt);
        chk("b2b.a_lat", 64'(cyc), 64'(33));
        chk("b2b.a_q", 64'(bus.quotient), 64'(2));
        launch(32'h0, 32'd1000, 32'd33, 1'b0);
        chk("b2b.b_busy_now", 64'(bus.busy), 64'(1));
        chk("b2b.b_done_low", 64'(bus.done), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        launch(32'h0, 32'd77, 32'd0, 1'b0);
        chk("b2b.ignored_done", 64'(bus.done), 64'(0));
        wait_done(6, cyc, bcnt);
        chk("b2b.b_lat", 64'(cyc), 64'(33));
        chk("b2b.b_q", 64'(bus.quotient), 64'(30));
        chk("b2b.b_r", 64'(bus.remainder), 64'(10));
        chk("b2b.b_dz", 64'(bus.div_zero), 64'(0));

        // Fast-path op accepted in the done cycle of a fast-path op
        launch(32'd5, 32'd0, 32'd5, 1'b0);
        chk("b2b.f1_done", 64'(bus.done), 64'(1));
        launch(32'h0, 32'd9, 32'd0, 1'b0);
        chk("b2b.f2_done", 64'(bus.done), 64'(1));
        chk("b2b.f2_flags", 64'({bus.div_zero, bus.overflow}), 64'(2'b10));
        chk("b2b.f2_r", 64'(bus.remainder), 64'(9));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
